// File: rtl/cordic_pkg.sv
// Shared CORDIC chain definitions: quadrant codes and angle-scaling helpers.
package cordic_pkg;

  typedef enum logic [1:0] {
    Q0 = 2'b00,
    Q1 = 2'b01,
    Q2 = 2'b10,
    Q3 = 2'b11
  } quad_t;

  localparam int ZWIDTH_DEF = 24;
  localparam int PWIDTH_DEF = 24;

  // z units: 2^ZWIDTH is pi.
  localparam longint unsigned PI_Z = 64'd1 << ZWIDTH_DEF;

  // Left shift taking a folded PWIDTH-1 bit phase onto the z angle scale.
  function automatic int z_shift(input int zw, input int pw);
    return zw - pw + 1;
  endfunction

endpackage

// File: rtl/nco_phase_acc.sv
// Stage 1: modular phase accumulator driven by carrier word plus deviation.
module nco_phase_acc
  import cordic_pkg::*;
#(
  parameter int PWIDTH = 24,
  parameter int MWIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PWIDTH-1:0]        freq,
  input  logic signed [MWIDTH-1:0] mod,
  input  logic                     phase_clr,
  input  logic                     stb_in,
  output logic [PWIDTH-1:0]        phase
);

  logic [PWIDTH-1:0] acc, acc_base, mod_ext, acc_next;

  assign mod_ext  = PWIDTH'(mod);
  assign acc_base = phase_clr ? '0 : acc;
  // Wraps modulo 2^PWIDTH on purpose: phase lives on a circle.
  assign acc_next = acc_base + freq + mod_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      phase <= '0;
    end else if (stb_in) begin
      acc   <= acc_next;
      phase <= acc_next;
    end else if (phase_clr) begin
      acc   <= '0;
    end
  end

endmodule

// File: rtl/cordic_phase_frontend.sv
// NCO phase accumulate + quadrant fold producing the initial CORDIC vector.
module cordic_phase_frontend
  import cordic_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ZWIDTH = ZWIDTH_DEF,
  parameter int PWIDTH = PWIDTH_DEF,
  parameter int MWIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PWIDTH-1:0]        freq,
  input  logic signed [MWIDTH-1:0] mod,
  input  logic [WIDTH-1:0]         amp,
  input  logic                     phase_clr,
  input  logic                     stb_in,
  output logic [WIDTH-1:0]         xo,
  output logic [WIDTH-1:0]         yo,
  output logic [ZWIDTH-1:0]        zo,
  output logic                     stb_out
);

  localparam int ZSH = z_shift(ZWIDTH, PWIDTH);

  logic [PWIDTH-1:0] p1;
  logic [WIDTH-1:0]  a1;
  logic              valid1;
  quad_t             q;
  logic              flip;

  nco_phase_acc #(.PWIDTH(PWIDTH), .MWIDTH(MWIDTH)) u_acc (
    .clk       (clk),
    .rst       (rst),
    .freq      (freq),
    .mod       (mod),
    .phase_clr (phase_clr),
    .stb_in    (stb_in),
    .phase     (p1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1     <= '0;
      valid1 <= 1'b0;
    end else begin
      valid1 <= stb_in;
      if (stb_in) a1 <= amp;
    end
  end

  assign q    = quad_t'(p1[PWIDTH-1:PWIDTH-2]);
  assign flip = (q == Q1) || (q == Q2);

  // Subtracting pi only inverts the MSB, which the z field drops anyway,
  // so the residual angle is just the low PWIDTH-1 phase bits rescaled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xo      <= '0;
      yo      <= '0;
      zo      <= '0;
      stb_out <= 1'b0;
    end else begin
      stb_out <= valid1;
      if (valid1) begin
        xo <= flip ? (~a1 + 1'b1) : a1;
        yo <= '0;
        zo <= {p1[PWIDTH-2:0], {ZSH{1'b0}}};
      end
    end
  end

endmodule

// File: tb/tb_cordic_phase_frontend.sv
// Directed vectors for cordic_phase_frontend with a queue-based scoreboard.
module tb_cordic_phase_frontend;
  import cordic_pkg::*;

  localparam int W = 16, Z = 24, P = 24, M = 16;

  logic         clk = 1'b0, rst = 1'b0;
  logic [P-1:0] freq = '0;
  logic [M-1:0] mod = '0;
  logic [W-1:0] amp = 16'h4000;
  logic         phase_clr = 1'b0, stb_in = 1'b0;
  logic [W-1:0] xo, yo;
  logic [Z-1:0] zo;
  logic         stb_out;

  typedef struct {
    logic [W-1:0] x;
    logic [Z-1:0] z;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0, bad = 0, cyc = 0;

  cordic_phase_frontend #(.WIDTH(W), .ZWIDTH(Z), .PWIDTH(P), .MWIDTH(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .freq      (freq),
    .mod       (mod),
    .amp       (amp),
    .phase_clr (phase_clr),
    .stb_in    (stb_in),
    .xo        (xo),
    .yo        (yo),
    .zo        (zo),
    .stb_out   (stb_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (stb_out === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_stb", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("xo", 32'(xo), 32'(e.x));
        chk("yo", 32'(yo), 32'd0);
        chk("zo", 32'(zo), 32'(e.z));
        chk("stb_latency", cyc, e.cyc);
      end
    end
  end

  task automatic send(input logic clr, input logic [P-1:0] f, input logic [M-1:0] m,
                      input logic [W-1:0] ex, input logic [Z-1:0] ez);
    exp_t e;
    @(negedge clk);
    phase_clr = clr; freq = f; mod = m; stb_in = 1'b1;
    e.x = ex; e.z = ez; e.cyc = cyc + 2;
    q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    phase_clr = 1'b0; stb_in = 1'b0; mod = '0;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    chk(name, q.size(), 0);
  endtask

  logic [Z-1:0] bz [8];
  logic [W-1:0] bx [8];
  logic [Z-1:0] half_pi_z;
  int           seen;

  initial begin
    bz = '{24'h200000, 24'h400000, 24'h600000, 24'h800000,
           24'hA00000, 24'hC00000, 24'hE00000, 24'h000000};
    bx = '{16'h4000, 16'h4000, 16'h4000, 16'hC000,
           16'hC000, 16'hC000, 16'hC000, 16'hC000};
    half_pi_z = Z'(PI_Z >> 1);

    // Async reset before any clock edge
    #1 rst = 1'b1;
    #2;
    chk("rst_xo", 32'(xo), 0); chk("rst_yo", 32'(yo), 0);
    chk("rst_zo", 32'(zo), 0); chk("rst_stb", 32'(stb_out), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Quadrant walk: pi/2, -pi, -pi/2, 0
    send(1'b0, 24'h400000, 16'h0, 16'hC000, half_pi_z);
    send(1'b0, 24'h400000, 16'h0, 16'hC000, 24'h000000);
    send(1'b0, 24'h400000, 16'h0, 16'h4000, 24'h800000);
    send(1'b0, 24'h400000, 16'h0, 16'h4000, 24'h000000);
    idle(); drain("drain_quad");

    // Fine angle pi/4
    send(1'b1, 24'h200000, 16'h0, 16'h4000, 24'h400000);
    idle(); drain("drain_fine");

    // Negative deviation
    send(1'b1, 24'h100000, 16'hF000, 16'h4000, 24'h1FE000);
    send(1'b0, 24'h100000, 16'hF000, 16'h4000, 24'h3FC000);
    send(1'b0, 24'h100000, 16'hF000, 16'h4000, 24'h5FA000);
    idle(); drain("drain_mod");

    // Wrap through 2pi
    send(1'b1, 24'hFFF000, 16'h0, 16'h4000, 24'hFFE000);
    send(1'b0, 24'h002000, 16'h0, 16'h4000, 24'h002000);
    idle(); drain("drain_wrap");

    // Clear alone: no strobe, outputs hold, accumulator restarts from 0
    @(negedge clk); phase_clr = 1'b1; stb_in = 1'b0;
    @(negedge clk); phase_clr = 1'b0;
    repeat (4) @(negedge clk);
    chk("hold_zo", 32'(zo), 32'h002000);
    chk("hold_xo", 32'(xo), 32'h4000);
    send(1'b0, 24'h100000, 16'h0, 16'h4000, 24'h200000);
    idle(); drain("drain_clr");

    // Back-to-back strobes
    for (int k = 0; k < 8; k++)
      send(k == 0, 24'h100000, 16'h0, bx[k], bz[k]);
    idle(); drain("drain_b2b");

    // Reset with a sample in flight
    @(negedge clk); freq = 24'h100000; stb_in = 1'b1;
    @(negedge clk); stb_in = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_xo", 32'(xo), 0); chk("mid_rst_yo", 32'(yo), 0);
    chk("mid_rst_zo", 32'(zo), 0); chk("mid_rst_stb", 32'(stb_out), 0);
    seen = 0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (stb_out === 1'b1) seen++;
    end
    chk("no_stb_after_rst", seen, 0);

    // Accumulator must restart from zero after reset
    send(1'b0, 24'h400000, 16'h0, 16'hC000, 24'h800000);
    idle(); drain("drain_post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/cordic_phase_frontend.md
Name: cordic_phase_frontend

Overview:
- Stage directly upstream of the first CORDIC rotation step in the FM-transmitter NCO/modulator chain.
- Accumulates phase from a carrier frequency word plus a signed FM deviation sample.
- Folds the full-circle phase into the CORDIC convergence range [-π/2, π/2) and emits the initial (x0, y0, z0) vector with a strobe, ready for step I=0.
- Two-stage register pipeline with strobe-qualified advance.

Parameters:
- WIDTH, 16, x/y datapath width (signed two's complement); must match the CORDIC chain.
- ZWIDTH, 24, z angle width; scaling 2^ZWIDTH = π, signed range ±π/2; must match the chain.
- PWIDTH, 24, phase accumulator width; 2^PWIDTH = 2π, wraps modulo 2π; constraint ZWIDTH ≥ PWIDTH-1.
- MWIDTH, 16, signed modulation (deviation) sample width; constraint MWIDTH ≤ PWIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- freq  in  PWIDTH  unsigned carrier phase increment per strobe.
- mod  in  MWIDTH  signed deviation increment, sign-extended to PWIDTH.
- amp  in  WIDTH  unsigned output magnitude; caller keeps amp·1.6468 < 2^(WIDTH-1).
- phase_clr  in  1  synchronous accumulator clear.
- stb_in  in  1  input sample valid; freq/mod/amp sampled when high.
- xo  out  WIDTH  initial x, ±amp.
- yo  out  WIDTH  initial y, always 0.
- zo  out  ZWIDTH  residual angle for the CORDIC chain.
- stb_out  out  1  output valid pulse.

Behaviour:
- Reset: clk and rst as named above; reset is asynchronous and active-high.
  - On rst: accumulator = 0, all pipeline registers = 0, xo = yo = zo = 0, stb_out = 0.
  - Deassertion is synchronous to clk by the system; the block samples nothing until the first stb_in after release.
- Stage 1 (accumulate): on clk when stb_in = 1:
  - acc_next = (phase_clr ? 0 : acc) + freq + sext(mod), all modulo 2^PWIDTH with no saturation.
  - acc <= acc_next; stage-1 phase register p1 <= acc_next; amplitude register a1 <= amp.
  - Wrap-around is silent by design: phase is a circle.
- phase_clr without stb_in: acc <= 0, p1 is untouched, no strobe is produced.
- phase_clr with stb_in in the same cycle: clear takes priority, then the add; acc = freq + sext(mod).
- Stage 2 (quadrant fold), on clk when the stage-1 valid is high:
  - Inspect the two MSBs of p1 as q = p1[PWIDTH-1:PWIDTH-2].
  - q = 00 or 11 (|phase| < π/2): flip = 0, f = p1.
  - q = 01 or 10: flip = 1, f = p1 with MSB inverted (phase − π, mod 2π).
  - f now lies in [-2^(PWIDTH-2), 2^(PWIDTH-2)).
  - zo <= {f[PWIDTH-2:0], (ZWIDTH-PWIDTH+1) zeros}.
  - xo <= flip ? −a1 : a1 (WIDTH-bit two's complement); yo <= 0.
- Strobe:
  - valid1 <= stb_in every clk; stb_out <= valid1 every clk.
  - stb_out is a single-cycle pulse exactly 2 clks after each stb_in; back-to-back stb_in gives back-to-back stb_out.
  - There is no backpressure.
- Outputs hold their last value between strobes; stage registers advance only on their valid.
- Reset mid-operation: in-flight samples are discarded and no stb_out is emitted for them.
- The only arithmetic is the modular add and the amp negation; there is no rounding.

Decomposition:
- Shared package (cordic_pkg): quadrant encodings (Q0=2'b00, Q1=2'b01, Q2=2'b10, Q3=2'b11).
- cordic_pkg also holds the angle-scaling constants: PI_Z = 2^ZWIDTH and the PWIDTH→ZWIDTH shift amount as a localparam function.
- One natural sub-module: nco_phase_acc, covering stage 1 (acc, clear, sign-extend, add). The fold logic stays in the top.

Test Plan (WIDTH=16, ZWIDTH=PWIDTH=24, amp=0x4000):
- Reset: assert rst asynchronously mid-cycle → xo/yo/zo/stb_out = 0 immediately; a pending stb_in issued 1 clk before rst never yields stb_out.
- Quadrant walk: freq=0x400000, mod=0, four strobes → stb_out pulses at +2 clks with:
  - (xo, zo) = (0xC000, 0x800000) for phase π/2;
  - (0xC000, 0x000000) for −π;
  - (0x4000, 0x800000) for −π/2;
  - (0x4000, 0x000000) for 0.
  - yo = 0 throughout.
- Fine angle: phase_clr+stb_in with freq=0x200000 → zo=0x400000 (π/4), xo=0x4000.
- Modulation: freq=0x100000, mod=−16'sd4096 (0xF000), 3 strobes from clear → acc = 3·0x0FF000 = 0x2FD000; zo = 0x5FA000, xo=0x4000.
- Wrap: acc preloaded via strobes to 0xFFF000, freq=0x002000 → acc=0x001000, q=00, zo=0x002000, no glitch on stb_out.
- Back-to-back: stb_in high 8 consecutive clks → stb_out high 8 consecutive clks starting 2 clks later; phase_clr alone (no stb_in) yields no stb_out.
